// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_responder
// Brief    : Peripheral-side responder for the CPU memory-mapped IO bus.
//            Owns the LED register, a debounced 16-bit switch input and a
//            sticky "confirm" button flag; returns 16-bit read data.
//            Optional macro IO_LED_READBACK_EN enables LED register readback.
// Revision : 1.0 - initial release
// ============================================================================
module io_responder #(
   parameter int DEBOUNCE_CYCLES = 200000   // stable cycles to accept an input, >= 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        LEDCtrl,
   input  logic        SwitchCtrl,
   input  logic [31:0] addr_in,
   input  logic [31:0] w_data,
   output logic [15:0] bdata,
   input  logic [15:0] sw_in,
   input  logic        btn_in,
   output logic [15:0] led_out
);

   localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [31:0]       c_addr_led = 32'hFFFF_FC60;
   localparam logic [31:0]       c_addr_sw  = 32'hFFFF_FC70;
   localparam logic [31:0]       c_addr_btn = 32'hFFFF_FC74;

   logic [15:0]         r_led;

   logic [15:0]         r_sw_meta;
   logic [15:0]         r_sw_sync;
   logic [15:0]         r_sw_stable;
   logic [c_cnt_w-1:0]  r_sw_cnt;

   logic                r_btn_meta;
   logic                r_btn_sync;
   logic                r_btn_stable;
   logic [c_cnt_w-1:0]  r_btn_cnt;
   logic                r_btn_prev;
   logic                r_btn_flag;

   logic                w_wr_led;
   logic                w_rd_btn;
   logic                w_btn_rise;
   logic                w_unused;

   // Decode is a full 32-bit compare so no address aliases onto a register.
   assign w_wr_led   = LEDCtrl && (addr_in == c_addr_led);
   assign w_rd_btn   = SwitchCtrl && (addr_in == c_addr_btn);
   assign w_btn_rise = r_btn_stable & ~r_btn_prev;
   assign led_out    = r_led;

   // Upper half of the CPU write data has no destination here.
   assign w_unused   = &{1'b0, w_data[31:16]};

   // LED register: loaded by a write to the LED address; reset wins over a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led <= 16'h0000;
      end else if (w_wr_led) begin
         r_led <= w_data[15:0];
      end
   end

   // Switch path: 2-FF synchronizer then a counter that must see the new value
   // for DEBOUNCE_CYCLES consecutive cycles; any return to the stable value
   // restarts the count, so short glitches never propagate.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_meta   <= 16'h0000;
         r_sw_sync   <= 16'h0000;
         r_sw_stable <= 16'h0000;
         r_sw_cnt    <= '0;
      end else begin
         r_sw_meta <= sw_in;
         r_sw_sync <= r_sw_meta;
         if (r_sw_sync == r_sw_stable) begin
            r_sw_cnt <= '0;
         end else if (r_sw_cnt == c_cnt_max) begin
            r_sw_stable <= r_sw_sync;
            r_sw_cnt    <= '0;
         end else begin
            r_sw_cnt <= r_sw_cnt + c_cnt_one;
         end
      end
   end

   // Button path: same synchronize-and-debounce structure with its own counter,
   // plus a one-cycle delayed copy for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_meta   <= 1'b0;
         r_btn_sync   <= 1'b0;
         r_btn_stable <= 1'b0;
         r_btn_cnt    <= '0;
         r_btn_prev   <= 1'b0;
      end else begin
         r_btn_meta <= btn_in;
         r_btn_sync <= r_btn_meta;
         r_btn_prev <= r_btn_stable;
         if (r_btn_sync == r_btn_stable) begin
            r_btn_cnt <= '0;
         end else if (r_btn_cnt == c_cnt_max) begin
            r_btn_stable <= r_btn_sync;
            r_btn_cnt    <= '0;
         end else begin
            r_btn_cnt <= r_btn_cnt + c_cnt_one;
         end
      end
   end

   // Sticky confirm flag: set by a debounced press, cleared by reading it.
   // A press coinciding with the clearing read keeps the flag set so the
   // press is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_flag <= 1'b0;
      end else if (w_btn_rise) begin
         r_btn_flag <= 1'b1;
      end else if (w_rd_btn) begin
         r_btn_flag <= 1'b0;
      end
   end

   // Read mux: zero unless the read select is high and the address matches.
   always_comb begin
      bdata = 16'h0000;
      if (SwitchCtrl) begin
         case (addr_in)
`ifdef IO_LED_READBACK_EN
            c_addr_led: bdata = r_led;
`endif
            c_addr_sw:  bdata = r_sw_stable;
            c_addr_btn: bdata = {15'b0, r_btn_flag};
            default:    bdata = 16'h0000;
         endcase
      end
   end

endmodule
`default_nettype wire
